// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the DDR3 application-port arbiter.
// Holds the controller command encodings, the arbiter states and the round-robin picker.
package ddr3_arb_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    // Wide enough for the maximum of four requesters.
    typedef logic [1:0] req_idx_t;

    // First requester with valid set, searching from last+1 and wrapping modulo n.
    function automatic req_idx_t rr_pick(input logic [3:0] valid, input req_idx_t last,
                                         input int unsigned n);
        req_idx_t pick;
        req_idx_t idx;
        logic     found;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = req_idx_t'((32'(last) + i) % n);
            if (i <= n && !found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ddr3_arb_tag_fifo.sv
// Tag FIFO: remembers which requester issued each outstanding read command.
// Pop-then-push is allowed when full; a pop while empty is ignored.
module ddr3_arb_tag_fifo
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  req_idx_t din,
    input  logic     pop,
    output req_idx_t dout,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    req_idx_t      mem [DEPTH];
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok)  rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= din;
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Round-robin burst arbiter sharing one DDR3 controller app port between NREQ requesters.
// Bursts are split into BL8 commands; read data is routed back through a tag FIFO.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned ADDR_W    = 28,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned ADDR_INC  = 8,
    parameter int unsigned TAG_DEPTH = 16
) (
    input  logic                             axi_aclk,
    input  logic                             axi_areset,
    input  logic [NREQ-1:0]                  req_valid,
    output logic [NREQ-1:0]                  req_ready,
    input  logic [NREQ-1:0]                  req_write,
    input  logic [NREQ-1:0][ADDR_W-1:0]      req_addr,
    input  logic [NREQ-1:0][LEN_W-1:0]       req_len,
    input  logic [NREQ-1:0]                  wr_valid,
    output logic [NREQ-1:0]                  wr_ready,
    input  logic [NREQ-1:0][DATA_W-1:0]      wr_data,
    input  logic [NREQ-1:0][DATA_W/8-1:0]    wr_mask,
    output logic [NREQ-1:0]                  rd_valid,
    output logic [DATA_W-1:0]                rd_data,
    output logic                             app_en,
    output logic [2:0]                       app_cmd,
    output logic [ADDR_W-1:0]                app_addr,
    input  logic                             app_rdy,
    output logic                             app_wdf_wren,
    output logic                             app_wdf_end,
    output logic [DATA_W-1:0]                app_wdf_data,
    output logic [DATA_W/8-1:0]              app_wdf_mask,
    input  logic                             app_wdf_rdy,
    input  logic                             app_rd_data_valid,
    input  logic [DATA_W-1:0]                app_rd_data,
    output logic                             rd_err
);

    localparam int unsigned CNT_W = LEN_W + 1;

    state_t               state;
    req_idx_t             gnt;
    req_idx_t             rr_ptr;
    req_idx_t             pick;
    logic                 wr_q;
    logic [LEN_W-1:0]     len_q;
    logic [CNT_W-1:0]     cmd_cnt;
    logic [CNT_W-1:0]     dat_cnt;
    logic [CNT_W-1:0]     cmd_nxt;
    logic [CNT_W-1:0]     dat_nxt;
    logic [CNT_W-1:0]     beats;
    logic [ADDR_W-1:0]    cmd_addr;

    logic                 sel_write;
    logic [ADDR_W-1:0]    sel_addr;
    logic [LEN_W-1:0]     sel_len;
    logic                 sel_wvalid;
    logic [DATA_W-1:0]    sel_wdata;
    logic [DATA_W/8-1:0]  sel_wmask;

    logic                 burst;
    logic                 wdf_open;
    logic                 cmd_fire;
    logic                 wdf_fire;
    logic                 done;
    logic                 tag_full;
    logic                 tag_empty;
    logic                 pop_ok;
    req_idx_t             tag_head;

    assign pick = rr_pick(4'(req_valid), rr_ptr, NREQ);

    always_comb begin
        sel_write  = 1'b0;
        sel_addr   = '0;
        sel_len    = '0;
        sel_wvalid = 1'b0;
        sel_wdata  = '0;
        sel_wmask  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt == req_idx_t'(i)) begin
                sel_write  = req_write[i];
                sel_addr   = req_addr[i];
                sel_len    = req_len[i];
                sel_wvalid = wr_valid[i];
                sel_wdata  = wr_data[i];
                sel_wmask  = wr_mask[i];
            end
        end
    end

    assign burst    = (state == BURST);
    assign beats    = CNT_W'(len_q) + 1'b1;
    assign wdf_open = burst && wr_q && (dat_cnt < beats);

    // Write commands trail accepted data beats so the controller never sees a command without data.
    assign app_en   = burst && (wr_q ? (dat_cnt > cmd_cnt) : ((cmd_cnt < beats) && !tag_full));
    assign app_cmd  = (burst && !wr_q) ? CMD_RD : CMD_WR;
    assign app_addr = cmd_addr;

    assign app_wdf_wren = wdf_open && sel_wvalid;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_data = wdf_open ? sel_wdata : '0;
    assign app_wdf_mask = wdf_open ? sel_wmask : '0;

    assign cmd_fire = app_en && app_rdy;
    assign wdf_fire = app_wdf_wren && app_wdf_rdy;
    assign cmd_nxt  = cmd_cnt + CNT_W'(cmd_fire);
    assign dat_nxt  = dat_cnt + CNT_W'(wdf_fire);
    assign done     = (cmd_nxt == beats) && (!wr_q || (dat_nxt == beats));

    assign pop_ok  = app_rd_data_valid && !tag_empty;
    assign rd_data = pop_ok ? app_rd_data : '0;

    always_comb begin
        wr_ready = '0;
        rd_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            wr_ready[i] = wdf_open && app_wdf_rdy && (gnt == req_idx_t'(i));
            rd_valid[i] = pop_ok && (tag_head == req_idx_t'(i));
        end
    end

    ddr3_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (axi_aclk),
        .rst   (axi_areset),
        .push  (cmd_fire && !wr_q),
        .din   (gnt),
        .pop   (app_rd_data_valid),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // IDLE grants in two steps: a registered req_ready pulse, then the fields are latched.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state     <= IDLE;
            rr_ptr    <= req_idx_t'(NREQ - 1);
            gnt       <= '0;
            req_ready <= '0;
            wr_q      <= 1'b0;
            len_q     <= '0;
            cmd_cnt   <= '0;
            dat_cnt   <= '0;
            cmd_addr  <= '0;
            rd_err    <= 1'b0;
        end else begin
            req_ready <= '0;
            if (app_rd_data_valid && tag_empty) rd_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        wr_q     <= sel_write;
                        len_q    <= sel_len;
                        cmd_addr <= sel_addr;
                        cmd_cnt  <= '0;
                        dat_cnt  <= '0;
                        state    <= BURST;
                    end else if (|req_valid) begin
                        for (int unsigned i = 0; i < NREQ; i++) begin
                            req_ready[i] <= (pick == req_idx_t'(i));
                        end
                        gnt    <= pick;
                        rr_ptr <= pick;
                    end
                end
                BURST: begin
                    cmd_cnt <= cmd_nxt;
                    dat_cnt <= dat_nxt;
                    if (cmd_fire) cmd_addr <= cmd_addr + ADDR_W'(ADDR_INC);
                    if (done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed self-checking bench for ddr3_port_arbiter (NREQ=2, TAG_DEPTH=16).
module tb_ddr3_port_arbiter;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_write;
    logic [1:0][27:0]    req_addr;
    logic [1:0][7:0]     req_len;
    logic [1:0]          wr_valid;
    logic [1:0]          wr_ready;
    logic [1:0][127:0]   wr_data;
    logic [1:0][15:0]    wr_mask;
    logic [1:0]          rd_valid;
    logic [127:0]        rd_data;
    logic                app_en;
    logic [2:0]          app_cmd;
    logic [27:0]         app_addr;
    logic                app_rdy;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic [127:0]        app_wdf_data;
    logic [15:0]         app_wdf_mask;
    logic                app_wdf_rdy;
    logic                app_rd_data_valid;
    logic [127:0]        app_rd_data;
    logic                rd_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddr3_port_arbiter #(
        .NREQ      (2),
        .ADDR_W    (28),
        .DATA_W    (128),
        .LEN_W     (8),
        .ADDR_INC  (8),
        .TAG_DEPTH (16)
    ) dut (
        .axi_aclk          (clk),
        .axi_areset        (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_len           (req_len),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_data           (wr_data),
        .wr_mask           (wr_mask),
        .rd_valid          (rd_valid),
        .rd_data           (rd_data),
        .app_en            (app_en),
        .app_cmd           (app_cmd),
        .app_addr          (app_addr),
        .app_rdy           (app_rdy),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_end       (app_wdf_end),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_mask      (app_wdf_mask),
        .app_wdf_rdy       (app_wdf_rdy),
        .app_rd_data_valid (app_rd_data_valid),
        .app_rd_data       (app_rd_data),
        .rd_err            (rd_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid         = '0;
        req_write         = '0;
        req_addr          = '0;
        req_len           = '0;
        wr_valid          = '0;
        wr_data           = '0;
        wr_mask           = '0;
        app_rdy           = 1'b1;
        app_wdf_rdy       = 1'b1;
        app_rd_data_valid = 1'b0;
        app_rd_data       = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        req_valid = 2'b11;
        rst = 1'b1;
        tick();
        tick();
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready got=%b exp=00", req_ready); end
        total++; if (app_en !== 1'b0) begin bad++; $display("FAIL rst_app_en got=%b exp=0", app_en); end
        total++; if (app_wdf_wren !== 1'b0) begin bad++; $display("FAIL rst_wdf_wren got=%b exp=0", app_wdf_wren); end
        total++; if (rd_valid !== 2'b00) begin bad++; $display("FAIL rst_rd_valid got=%b exp=00", rd_valid); end
        total++; if (rd_err !== 1'b0) begin bad++; $display("FAIL rst_rd_err got=%b exp=0", rd_err); end
        total++; if (app_addr !== 28'h0) begin bad++; $display("FAIL rst_app_addr got=%h exp=0", app_addr); end
        clear_inputs();
    endtask

    task automatic test_single_write();
        int unsigned pulses = 0;
        int unsigned ncmd   = 0;
        int unsigned nbeat  = 0;
        logic drop = 1'b0;
        logic lead = 1'b0;
        logic cf, wf;
        logic [27:0]  exp_addr;
        logic [127:0] exp_data;
        do_reset();
        req_write[0] = 1'b1;
        req_addr[0]  = 28'h100;
        req_len[0]   = 8'd3;
        wr_valid[0]  = 1'b1;
        wr_data[0]   = 128'hA000;
        req_valid[0] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (req_ready[0]) begin pulses++; drop = 1'b1; end
            cf = app_en && app_rdy;
            wf = app_wdf_wren && app_wdf_rdy;
            if (app_en && ncmd >= nbeat) lead = 1'b1;
            if (cf) begin
                exp_addr = 28'h100 + 28'(ncmd * 8);
                total++;
                if (app_addr !== exp_addr || app_cmd !== 3'b000) begin
                    bad++; $display("FAIL wr_cmd%0d got addr=%h cmd=%b exp addr=%h cmd=000", ncmd, app_addr, app_cmd, exp_addr);
                end
                ncmd++;
            end
            if (wf) begin
                exp_data = 128'hA000 + 128'(nbeat);
                total++;
                if (app_wdf_data !== exp_data || app_wdf_end !== 1'b1) begin
                    bad++; $display("FAIL wr_beat%0d got data=%h end=%b exp data=%h end=1", nbeat, app_wdf_data, app_wdf_end, exp_data);
                end
                nbeat++;
            end
            tick();
            if (drop) req_valid[0] = 1'b0;
            if (wf) wr_data[0] = 128'hA000 + 128'(nbeat);
        end
        wr_valid[0] = 1'b0;
        #1;
        total++; if (pulses != 1) begin bad++; $display("FAIL wr_ready_pulses got=%0d exp=1", pulses); end
        total++; if (ncmd != 4) begin bad++; $display("FAIL wr_cmd_count got=%0d exp=4", ncmd); end
        total++; if (nbeat != 4) begin bad++; $display("FAIL wr_beat_count got=%0d exp=4", nbeat); end
        total++; if (lead !== 1'b0) begin bad++; $display("FAIL wr_cmd_leads_data got=%b exp=0", lead); end
        total++; if (app_en !== 1'b0 || wr_ready !== 2'b00) begin bad++; $display("FAIL wr_idle got en=%b wr_ready=%b exp 0/00", app_en, wr_ready); end
    endtask

    task automatic test_alternate();
        logic [1:0]  grants [4];
        logic [27:0] addrs [4];
        int unsigned ng = 0;
        int unsigned na = 0;
        logic drop = 1'b0;
        logic [1:0]  exp_g;
        logic [27:0] exp_a;
        do_reset();
        req_addr[0] = 28'h200;
        req_addr[1] = 28'h300;
        req_valid   = 2'b11;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (req_ready != 2'b00 && ng < 4) begin
                grants[ng] = req_ready;
                ng++;
                if (ng == 4) drop = 1'b1;
            end
            if (app_en && app_rdy) begin
                if (na < 4) addrs[na] = app_addr;
                na++;
            end
            tick();
            if (drop) req_valid = 2'b00;
        end
        total++; if (ng != 4 || na != 4) begin bad++; $display("FAIL alt_counts got grants=%0d cmds=%0d exp 4/4", ng, na); end
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (k % 2 == 0) ? 28'h200 : 28'h300;
            total++;
            if (grants[k] !== exp_g || addrs[k] !== exp_a) begin
                bad++; $display("FAIL alt_grant%0d got ready=%b addr=%h exp ready=%b addr=%h", k, grants[k], addrs[k], exp_g, exp_a);
            end
        end
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            app_rd_data_valid = 1'b1;
            app_rd_data = 128'hB0 + 128'(k);
            #1;
            total++;
            if (rd_valid !== exp_g || rd_data !== 128'hB0 + 128'(k)) begin
                bad++; $display("FAIL alt_return%0d got rd_valid=%b data=%h exp rd_valid=%b data=%h", k, rd_valid, rd_data, exp_g, 128'hB0 + 128'(k));
            end
            tick();
        end
        app_rd_data_valid = 1'b0;
    endtask

    task automatic test_routing();
        logic [27:0] addrs [5];
        logic [27:0] exp_list [5];
        logic [1:0]  exp_v;
        int unsigned na = 0;
        logic r0 = 1'b0;
        logic r1 = 1'b0;
        logic started0 = 1'b0;
        exp_list[0] = 28'h400; exp_list[1] = 28'h408;
        exp_list[2] = 28'h500; exp_list[3] = 28'h508; exp_list[4] = 28'h510;
        do_reset();
        req_addr[1] = 28'h400; req_len[1] = 8'd1;
        req_addr[0] = 28'h500; req_len[0] = 8'd2;
        req_valid   = 2'b10;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req_ready[1]) r1 = 1'b1;
            if (req_ready[0]) r0 = 1'b1;
            if (app_en && app_rdy) begin
                if (na < 5) addrs[na] = app_addr;
                na++;
            end
            tick();
            if (r1 && !started0) begin req_valid = 2'b01; started0 = 1'b1; end
            if (r0) req_valid[0] = 1'b0;
        end
        total++; if (na != 5) begin bad++; $display("FAIL route_cmd_count got=%0d exp=5", na); end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (addrs[k] !== exp_list[k]) begin bad++; $display("FAIL route_addr%0d got=%h exp=%h", k, addrs[k], exp_list[k]); end
        end
        for (int k = 0; k < 5; k++) begin
            exp_v = (k < 2) ? 2'b10 : 2'b01;
            app_rd_data_valid = 1'b1;
            app_rd_data = 128'hC0 + 128'(k);
            #1;
            total++;
            if (rd_valid !== exp_v || rd_data !== 128'hC0 + 128'(k)) begin
                bad++; $display("FAIL route_return%0d got rd_valid=%b data=%h exp rd_valid=%b data=%h", k, rd_valid, rd_data, exp_v, 128'hC0 + 128'(k));
            end
            tick();
        end
        app_rd_data_valid = 1'b0;
        #1;
        total++; if (rd_err !== 1'b0) begin bad++; $display("FAIL route_rd_err got=%b exp=0", rd_err); end
    endtask

    task automatic test_app_rdy_stall();
        int unsigned n = 0;
        logic drop = 1'b0;
        logic stalled = 1'b0;
        do_reset();
        req_addr[0]  = 28'h600;
        req_len[0]   = 8'd7;
        req_valid[0] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (req_ready[0]) drop = 1'b1;
            if (app_en && app_rdy) begin
                total++;
                if (app_addr !== 28'h600 + 28'(n * 8) || app_cmd !== 3'b001) begin
                    bad++; $display("FAIL stall_cmd%0d got addr=%h cmd=%b exp addr=%h cmd=001", n, app_addr, app_cmd, 28'h600 + 28'(n * 8));
                end
                n++;
            end
            tick();
            if (drop) req_valid[0] = 1'b0;
            if (n == 2 && !stalled) begin
                stalled = 1'b1;
                app_rdy = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    total++;
                    if (app_en !== 1'b1 || app_addr !== 28'h610) begin
                        bad++; $display("FAIL stall_hold%0d got en=%b addr=%h exp en=1 addr=0000610", s, app_en, app_addr);
                    end
                    tick();
                end
                app_rdy = 1'b1;
            end
        end
        total++; if (n != 8) begin bad++; $display("FAIL stall_cmd_count got=%0d exp=8", n); end
        for (int k = 0; k < 8; k++) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = 128'hD0 + 128'(k);
            #1;
            total++;
            if (rd_valid !== 2'b01) begin bad++; $display("FAIL stall_return%0d got rd_valid=%b exp=01", k, rd_valid); end
            tick();
        end
        #1;
        total++;
        if (rd_valid !== 2'b00 || rd_err !== 1'b0) begin
            bad++; $display("FAIL stall_drained got rd_valid=%b rd_err=%b exp 00/0", rd_valid, rd_err);
        end
        tick();
        app_rd_data_valid = 1'b0;
        #1;
        total++; if (rd_err !== 1'b1) begin bad++; $display("FAIL stall_extra_tag got rd_err=%b exp=1", rd_err); end
    endtask

    task automatic test_tag_full();
        int unsigned n = 0;
        int unsigned m = 0;
        logic drop = 1'b0;
        do_reset();
        req_addr[0]  = 28'hFFFFFF8;
        req_len[0]   = 8'd31;
        req_valid[0] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (req_ready[0]) drop = 1'b1;
            if (app_en && app_rdy) begin
                if (n == 1) begin
                    total++;
                    if (app_addr !== 28'h0000000) begin bad++; $display("FAIL full_addr_wrap got=%h exp=0000000", app_addr); end
                end
                n++;
            end
            tick();
            if (drop) req_valid[0] = 1'b0;
        end
        #1;
        total++; if (n != 16) begin bad++; $display("FAIL full_cmd_count got=%0d exp=16", n); end
        total++; if (app_en !== 1'b0) begin bad++; $display("FAIL full_app_en got=%b exp=0", app_en); end
        app_rd_data_valid = 1'b1;
        app_rd_data = 128'hE0;
        #1;
        total++; if (rd_valid !== 2'b01) begin bad++; $display("FAIL full_pop got rd_valid=%b exp=01", rd_valid); end
        tick();
        app_rd_data_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (app_en && app_rdy) m++;
            tick();
        end
        #1;
        total++; if (m != 1) begin bad++; $display("FAIL full_refill got=%0d exp=1", m); end
        total++; if (app_en !== 1'b0) begin bad++; $display("FAIL full_app_en_again got=%b exp=0", app_en); end
    endtask

    task automatic test_reset_mid_write();
        int unsigned w = 0;
        logic found = 1'b0;
        logic drop = 1'b0;
        logic [1:0] first = 2'b00;
        do_reset();
        req_write[0] = 1'b1;
        req_addr[0]  = 28'h700;
        req_len[0]   = 8'd7;
        wr_valid[0]  = 1'b1;
        wr_data[0]   = 128'hF00;
        req_valid[0] = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            #1;
            if (req_ready[0]) drop = 1'b1;
            if (app_wdf_wren && w == 1) begin
                found = 1'b1;
            end else begin
                if (app_wdf_wren && app_wdf_rdy) w++;
                tick();
                if (drop) req_valid[0] = 1'b0;
            end
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rmw_second_beat got=%b exp=1", found); end
        rst = 1'b1;
        #1;
        total++;
        if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0 || wr_ready !== 2'b00 || req_ready !== 2'b00) begin
            bad++; $display("FAIL rmw_abort got en=%b wren=%b end=%b wr_ready=%b req_ready=%b exp all 0", app_en, app_wdf_wren, app_wdf_end, wr_ready, req_ready);
        end
        tick();
        tick();
        clear_inputs();
        rst = 1'b0;
        #1;
        app_rd_data_valid = 1'b1;
        app_rd_data = 128'h5A5A;
        #1;
        total++; if (rd_valid !== 2'b00) begin bad++; $display("FAIL rmw_orphan_route got=%b exp=00", rd_valid); end
        tick();
        app_rd_data_valid = 1'b0;
        #1;
        total++; if (rd_err !== 1'b1) begin bad++; $display("FAIL rmw_rd_err got=%b exp=1", rd_err); end
        req_valid = 2'b11;
        for (int c = 0; c < 10 && first == 2'b00; c++) begin
            #1;
            if (req_ready != 2'b00) first = req_ready;
            else tick();
        end
        total++; if (first !== 2'b01) begin bad++; $display("FAIL rmw_first_grant got=%b exp=01", first); end
        tick();
        req_valid = 2'b00;
        repeat (6) tick();
        total++; if (rd_err !== 1'b1) begin bad++; $display("FAIL rmw_rd_err_sticky got=%b exp=1", rd_err); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_alternate();
        test_routing();
        test_app_rdy_stall();
        test_tag_full();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
